branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter instruction_width, default 32, SHALL set the width of every PC and target bus.
REQ-002 Parameter ENTRIES, default 16, power of two, SHALL set the table depth; IDX_W = log2(ENTRIES).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 lookup_pc  input  instruction_width  SHALL be the fetch-stage PC being looked up.
REQ-006 pred_hit  output  1  SHALL indicate that a valid entry's tag matches lookup_pc.
REQ-007 pred_taken  output  1  SHALL be the taken prediction for lookup_pc.
REQ-008 pred_target  output  instruction_width  SHALL be the predicted next PC.
REQ-009 upd_valid  input  1  SHALL qualify a resolved-branch update from the execute stage.
REQ-010 upd_pc  input  instruction_width  SHALL be the PC of the resolved branch.
REQ-011 upd_taken  input  1  SHALL be the resolved branch outcome.
REQ-012 upd_target  input  instruction_width  SHALL be the computed branch target (pc_next + imm<<2).
REQ-013 flush  input  1  SHALL request invalidation of all entries.

Function
REQ-014 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[instruction_width-1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-015 Lookup SHALL be combinational from stored state: pred_hit = valid[idx] && tag[idx]==lookup tag.
REQ-016 pred_taken SHALL be pred_hit && ctr[idx][1].
REQ-017 pred_target SHALL be target[idx] when pred_taken, else lookup_pc + 4, with the sum truncated to instruction_width (wraps at 0xFFFFFFFC -> 0x00000000).
REQ-018 Each entry SHALL hold valid, tag, target, and a 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-019 On upd_valid with a tag hit, the counter SHALL increment on upd_taken and decrement otherwise, saturating at 11 and 00.
REQ-020 On upd_valid with a tag hit and upd_taken=1, the target SHALL be overwritten with upd_target.
REQ-021 On upd_valid with a miss and upd_taken=1, the entry SHALL be allocated: valid=1, the new tag, target=upd_target, ctr=10.
REQ-022 On upd_valid with a miss and upd_taken=0, the table SHALL be unchanged.
REQ-023 Update effects SHALL become visible to lookup on the cycle after the update edge; same-cycle lookup of the index being updated SHALL return the old contents (no bypass).
REQ-024 flush SHALL clear every valid bit at the next edge; counters, tags and targets SHALL be left unchanged.
REQ-025 If flush and upd_valid are both asserted in the same cycle, flush SHALL win and the update SHALL be dropped.
REQ-026 Only one update per cycle SHALL be supported; there is no backpressure, and updates SHALL always be accepted.

Reset
REQ-027 While rst_n=0, all valid bits SHALL be 0, counters 01, and tags and targets 0.
REQ-028 While in reset, pred_hit=0, pred_taken=0, and pred_target=lookup_pc+4.
REQ-029 Reset asserted mid-update SHALL discard the update; the first update accepted is on the first rising edge with rst_n=1.

Structure
REQ-030 A shared package/header btb_pkg SHALL hold the ENTRIES default, IDX_W and TAG_W derivations, and the counter encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
REQ-031 The saturating counter SHALL be a sub-module btb_sat_counter (inputs: cur, inc, en; output: next), instantiated per write port, not per entry.
REQ-032 Storage SHALL be flops (no SRAM macro), with one write port and one combinational read port.

Verification
REQ-033 Reset, then lookup_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0x00000044.
REQ-034 Update pc=0x00000040, taken, target=0x00000100; next cycle lookup 0x40 -> hit=1, taken=1, target=0x00000100.
REQ-035 Two not-taken updates on 0x40 (ctr 10->01->00), then lookup -> hit=1, taken=0, target=0x44; a third not-taken update leaves ctr at 00.
REQ-036 Update pc=0x00000440 taken (same index as 0x40, new tag) -> a lookup of 0x40 misses, and a lookup of 0x440 hits with ctr=10.
REQ-037 flush together with a taken update of 0x80 -> the next cycle, lookups of 0x40 and 0x80 both miss.
REQ-038 lookup_pc=0xFFFFFFFC with a miss -> pred_target=0x00000000; rst_n dropped mid-sequence -> all lookups miss immediately.

Source files
------------

// File: rtl/btb_pkg.sv
// btb_pkg: shared BTB defaults, index/tag width derivations and 2-bit counter encodings
package btb_pkg;
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_IW = 32;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
  function automatic int tag_w(input int iw, input int entries);
    return iw - $clog2(entries) - 2;
  endfunction
  localparam int IDX_W = idx_w(DEF_ENTRIES);
  localparam int TAG_W = tag_w(DEF_IW, DEF_ENTRIES);
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;
endpackage

// File: rtl/btb_sat_counter.sv
// btb_sat_counter: 2-bit saturating counter step; cur/inc/en in, next out (next=cur when en=0)
module btb_sat_counter
  import btb_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  input  logic       en,
  output logic [1:0] next
);
  assign next = !en ? cur :
                inc ? (cur == CTR_ST ? cur : cur + 2'd1) :
                      (cur == CTR_SNT ? cur : cur - 2'd1);
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB; clk/rst_n, lookup_pc -> pred_hit/pred_taken/pred_target, upd_valid/upd_pc/upd_taken/upd_target write port, flush clears valids
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int instruction_width = 32,
  parameter int ENTRIES = DEF_ENTRIES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [instruction_width-1:0] lookup_pc,
  output logic                         pred_hit,
  output logic                         pred_taken,
  output logic [instruction_width-1:0] pred_target,
  input  logic                         upd_valid,
  input  logic [instruction_width-1:0] upd_pc,
  input  logic                         upd_taken,
  input  logic [instruction_width-1:0] upd_target,
  input  logic                         flush
);
  localparam int IW = idx_w(ENTRIES);
  localparam int TW = tag_w(instruction_width, ENTRIES);
  logic [ENTRIES-1:0]           valid_q;
  logic [TW-1:0]                tag_q    [ENTRIES];
  logic [instruction_width-1:0] target_q [ENTRIES];
  logic [1:0]                   ctr_q    [ENTRIES];
  logic [IW-1:0]                l_idx, u_idx;
  logic [TW-1:0]                l_tag, u_tag;
  logic                         u_hit;
  logic [1:0]                   ctr_next;
  logic                         unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};
  assign l_idx = lookup_pc[IW+1:2];
  assign l_tag = lookup_pc[instruction_width-1:IW+2];
  assign u_idx = upd_pc[IW+1:2];
  assign u_tag = upd_pc[instruction_width-1:IW+2];
  assign pred_hit    = valid_q[l_idx] && tag_q[l_idx] == l_tag;
  assign pred_taken  = pred_hit && ctr_q[l_idx][1];
  assign pred_target = pred_taken ? target_q[l_idx] : lookup_pc + instruction_width'(4);
  assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  btb_sat_counter u_ctr (
    .cur  (ctr_q[u_idx]),
    .inc  (upd_taken),
    .en   (u_hit),
    .next (ctr_next)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (flush)
      valid_q <= '0;
    else if (upd_valid && u_hit) begin
      ctr_q[u_idx] <= ctr_next;
      if (upd_taken) target_q[u_idx] <= upd_target;
    end else if (upd_valid && upd_taken) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
      ctr_q[u_idx]    <= CTR_WT;
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: scoreboard bench for branch_target_buffer against a behavioural table model
module tb_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        flush = 1'b0;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mv [16];
  logic [25:0] mt [16];
  logic [31:0] mg [16];
  logic [1:0]  mc [16];
  logic [31:0] pcs [8];
  branch_target_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush       (flush)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      mt[i] = '0;
      mg[i] = '0;
      mc[i] = 2'b01;
    end
  endtask
  task automatic model_apply(input logic uv, input logic [31:0] upc, input logic ut,
                             input logic [31:0] utgt, input logic fl);
    int  j;
    logic uh;
    j  = int'(upc[5:2]);
    uh = mv[j] && mt[j] == upc[31:6];
    if (fl) begin
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    end else if (uv && uh) begin
      if (ut) mc[j] = (mc[j] == 2'b11) ? 2'b11 : mc[j] + 2'd1;
      else    mc[j] = (mc[j] == 2'b00) ? 2'b00 : mc[j] - 2'd1;
      if (ut) mg[j] = utgt;
    end else if (uv && ut) begin
      mv[j] = 1'b1;
      mt[j] = upc[31:6];
      mg[j] = utgt;
      mc[j] = 2'b10;
    end
  endtask
  // One cycle: drive lookup and optional update, check the lookup against the
  // pre-edge model (so a same-index update must not be bypassed), then clock it in.
  task automatic step(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic fl);
    int          i;
    logic        h, t;
    logic [31:0] g;
    exp_t        e;
    lookup_pc  = lpc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utgt;
    flush      = fl;
    i = int'(lpc[5:2]);
    h = rst_n && mv[i] && mt[i] == lpc[31:6];
    t = h && mc[i][1];
    g = t ? mg[i] : lpc + 32'd4;
    sb.push_back('{tag: "hit",    exp: {31'b0, h}});
    sb.push_back('{tag: "taken",  exp: {31'b0, t}});
    sb.push_back('{tag: "target", exp: g});
    @(negedge clk);
    e = sb.pop_front(); check(e.tag, {31'b0, pred_hit}, e.exp);
    e = sb.pop_front(); check(e.tag, {31'b0, pred_taken}, e.exp);
    e = sb.pop_front(); check(e.tag, pred_target, e.exp);
    @(posedge clk);
    if (rst_n) model_apply(uv, upc, ut, utgt, fl);
    #1;
    upd_valid = 1'b0;
    flush     = 1'b0;
  endtask
  task automatic look(input logic [31:0] pc);
    step(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    step(pc, 1'b1, pc, t, tgt, 1'b0);
  endtask
  initial begin
    pcs = '{32'h40, 32'h440, 32'h80, 32'h84, 32'hFFFFFFFC, 32'h8C4, 32'h1040, 32'h7C};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    look(32'h40);
    rst_n = 1'b1;
    look(32'h40);
    upd(32'h40, 1'b1, 32'h100);
    look(32'h40);
    upd(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0);
    look(32'h40);
    upd(32'h40, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h200);
    look(32'h40);
    upd(32'h40, 1'b1, 32'h300);
    look(32'h40);
    upd(32'h440, 1'b1, 32'h500);
    look(32'h40);
    look(32'h440);
    upd(32'h440, 1'b0, 32'h0);
    look(32'h440);
    upd(32'h40, 1'b1, 32'h600);
    step(32'h80, 1'b1, 32'h80, 1'b1, 32'h900, 1'b1);
    look(32'h40);
    look(32'h80);
    look(32'h440);
    upd(32'h80, 1'b0, 32'h0);
    look(32'h80);
    look(32'hFFFFFFFC);
    upd(32'hFFFFFFFC, 1'b1, 32'h1000);
    look(32'hFFFFFFFC);
    upd(32'h40, 1'b1, 32'h700);
    look(32'h40);
    rst_n = 1'b0;
    model_reset();
    #1;
    look(32'h40);
    upd(32'h40, 1'b1, 32'h800);
    look(32'hFFFFFFFC);
    rst_n = 1'b1;
    look(32'h40);
    upd(32'h40, 1'b1, 32'h900);
    look(32'h40);
    for (int k = 0; k < 300; k++)
      step(pcs[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 7)],
           1'($urandom_range(0, 1)), $urandom & 32'hFFFFFFFC, $urandom_range(0, 19) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
